// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill memory model: request type codes,
// responder FSM states, and the line/word geometry.
package cache_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT
  } state_e;

  // Line writes touch all 16 bytes; anything else lands in one word under its strobes.
  function automatic logic [15:0] byte_en(input logic [2:0] typ,
                                          input logic [1:0] word,
                                          input logic [3:0] strb);
    if (typ == TYPE_LINE) return '1;
    return 16'(strb) << {word, 2'b00};
  endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Line-granular storage: 2^LINE_AW x 128 bits, one byte-enabled write port
// and one asynchronous word-select read port.
module cache_mem_array
  import cache_pkg::*;
#(
  parameter int unsigned LINE_AW = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [LINE_AW-1:0] waddr_i,
  input  logic [15:0]        wbe_i,
  input  logic [LINE_W-1:0]  wdata_i,
  input  logic [LINE_AW-1:0] raddr_i,
  input  logic [1:0]         rword_i,
  output logic [WORD_W-1:0]  rdata_o
);

  logic [LINE_W-1:0] mem_q [2**LINE_AW];
  logic [LINE_W-1:0] line_rd;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 16; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign line_rd = mem_q[raddr_i];
  assign rdata_o = line_rd[32*rword_i +: 32];

endmodule

// File: rtl/cache_refill_mem.sv
// Backing-memory responder for the cache refill/write-back port.
// Define CACHE_REFILL_MEM_INIT_EN to sweep the array with address patterns after reset.
module cache_refill_mem
  import cache_pkg::*;
#(
  parameter int unsigned LINE_AW = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_req,
  input  logic [2:0]          rd_type,
  input  logic [31:0]         rd_addr,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic                ret_last,
  output logic [WORD_W-1:0]   ret_data,
  input  logic                wr_req,
  input  logic [2:0]          wr_type,
  input  logic [31:0]         wr_addr,
  input  logic [3:0]          wr_wstrb,
  input  logic [LINE_W-1:0]   wr_data,
  output logic                wr_rdy
);

  state_e             state_q, state_d;
  logic [3:0]         lat_q, lat_d;
  logic [1:0]         beat_q, beat_d;
  logic [1:0]         word_q, word_d;
  logic               burst_q, burst_d;
  logic [LINE_AW-1:0] line_q, line_d;
  logic [15:0]        wbe_q, wbe_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;

  logic               we;
  logic [15:0]        mem_wbe;
  logic [LINE_W-1:0]  mem_wdata;
  logic [WORD_W-1:0]  rd_word;
  logic               unused_addr;

  assign unused_addr = ^{rd_addr[31:LINE_AW+4], rd_addr[1:0],
                         wr_addr[31:LINE_AW+4], wr_addr[1:0]};

`ifdef CACHE_REFILL_MEM_INIT_EN
  logic [LINE_W-1:0] init_line;

  always_comb begin
    init_line = '0;
    for (int unsigned w = 0; w < 4; w++) begin
      init_line[32*w +: 32] = 32'({line_q, 2'(w), 2'b00});
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    word_d    = word_q;
    burst_d   = burst_q;
    line_d    = line_q;
    wbe_d     = wbe_q;
    wdata_d   = wdata_q;
    we        = 1'b0;
    mem_wbe   = wbe_q;
    mem_wdata = wdata_q;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    case (state_q)
`ifdef CACHE_REFILL_MEM_INIT_EN
      INIT: begin
        we        = 1'b1;
        mem_wbe   = '1;
        mem_wdata = init_line;
        line_d    = line_q + 1'b1;
        if (line_q == '1) state_d = IDLE;
      end
`endif
      IDLE: begin
        if (wr_req) begin
          line_d  = wr_addr[LINE_AW+3:4];
          wbe_d   = byte_en(wr_type, wr_addr[3:2], wr_wstrb);
          wdata_d = (wr_type == TYPE_LINE) ? wr_data : {4{wr_data[31:0]}};
          lat_d   = 4'(LATENCY);
          state_d = WR_WAIT;
        end else if (rd_req) begin
          line_d  = rd_addr[LINE_AW+3:4];
          word_d  = rd_addr[3:2];
          burst_d = (rd_type == TYPE_LINE);
          beat_d  = '0;
          lat_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RD_BURST : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q == 4'd1) state_d = RD_BURST;
        else               lat_d   = lat_q - 4'd1;
      end
      RD_BURST: begin
        ret_valid = 1'b1;
        ret_last  = !burst_q || (beat_q == 2'd3);
        if (ret_last) state_d = IDLE;
        else          beat_d  = beat_q + 2'd1;
      end
      WR_WAIT: begin
        if (lat_q == 4'd1) begin
          we      = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef CACHE_REFILL_MEM_INIT_EN
      state_q <= INIT;
`else
      state_q <= IDLE;
`endif
      lat_q   <= '0;
      beat_q  <= '0;
      word_q  <= '0;
      burst_q <= 1'b0;
      line_q  <= '0;
      wbe_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      burst_q <= burst_d;
      line_q  <= line_d;
      wbe_q   <= wbe_d;
      wdata_q <= wdata_d;
    end
  end

  assign rd_rdy   = (state_q == IDLE) && !wr_req;
  assign wr_rdy   = (state_q == IDLE);
  assign ret_data = ret_valid ? rd_word : '0;

  // Reset on the commit edge suppresses the write so a pending store is discarded.
  cache_mem_array #(
    .LINE_AW(LINE_AW)
  ) u_array (
    .clk     (clk),
    .we_i    (we && !reset),
    .waddr_i (line_q),
    .wbe_i   (mem_wbe),
    .wdata_i (mem_wdata),
    .raddr_i (line_q),
    .rword_i (burst_q ? beat_q : word_q),
    .rdata_o (rd_word)
  );

endmodule

// File: tb/tb_cache_refill_mem.sv
// Directed bench for cache_refill_mem (LATENCY=2, LINE_AW=8); handles both
// builds with and without CACHE_REFILL_MEM_INIT_EN.
module tb_cache_refill_mem;
  import cache_pkg::*;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_refill_mem #(
    .LINE_AW(8),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy)
  );

  typedef struct {
    bit            is_wr;
    logic [2:0]    typ;
    logic [31:0]   addr;
    logic [3:0]    strb;
    logic [127:0]  data;
    int            nbeats;
    logic [127:0]  exp;   // beat b expected in exp[32*b +: 32]
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                          input logic [127:0] d, input string name);
    int n;
    int low;
    @(negedge clk);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
    #1;
    n = 0;
    while (!wr_rdy && n < 400) begin @(negedge clk); #1; n++; end
    check($sformatf("%s wr_rdy", name), 32'(wr_rdy), 32'd1);
    @(posedge clk);
    #1 wr_req = 1'b0;
    low = 0;
    do begin
      @(negedge clk);
      if (!wr_rdy) low++;
    end while (!wr_rdy && low < 20);
    check($sformatf("%s wr_busy_cycles", name), 32'(low), 32'(LAT));
  endtask

  task automatic do_read(input logic [2:0] t, input logic [31:0] a, input int nbeats,
                         input logic [127:0] exp, input string name);
    int n;
    int k;
    @(negedge clk);
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    #1;
    n = 0;
    while (!rd_rdy && n < 400) begin @(negedge clk); #1; n++; end
    check($sformatf("%s rd_rdy", name), 32'(rd_rdy), 32'd1);
    @(posedge clk);
    #1 rd_req = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ret_valid && k < 20);
    check($sformatf("%s latency", name), 32'(k), 32'(LAT));
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) @(negedge clk);
      check($sformatf("%s beat%0d data", name, b), ret_data, exp[32*b +: 32]);
      check($sformatf("%s beat%0d valid", name, b), 32'(ret_valid), 32'd1);
      check($sformatf("%s beat%0d last", name, b), 32'(ret_last), 32'(b == nbeats - 1));
      check($sformatf("%s beat%0d rdy", name, b), 32'(rd_rdy | wr_rdy), 32'd0);
    end
    @(negedge clk);
    check($sformatf("%s post valid", name), 32'(ret_valid), 32'd0);
    check($sformatf("%s post data", name), ret_data, 32'd0);
    check($sformatf("%s post rdy", name), 32'(rd_rdy), 32'd1);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!wr_rdy && n < 400) begin @(negedge clk); n++; end
    check($sformatf("%s ready_after_reset", name), 32'(wr_rdy), 32'd1);
  endtask

  vec_t         vecs [9];
  logic [127:0] pat120;
  logic [127:0] old340;

  initial begin
    rd_req = 0; rd_type = '0; rd_addr = '0;
    wr_req = 0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    pat120 = {32'h12C, 32'h128, 32'h124, 32'h120};

    vecs[0] = '{1'b1, TYPE_LINE, 32'h340, 4'h0,
                128'h44444444_33333333_22222222_11111111, 0, '0};
    vecs[1] = '{1'b0, TYPE_LINE, 32'h340, 4'h0, '0, 4,
                128'h44444444_33333333_22222222_11111111};
    vecs[2] = '{1'b1, TYPE_WORD, 32'h348, 4'b0111, 128'hAABBCCDD, 0, '0};
    vecs[3] = '{1'b0, TYPE_WORD, 32'h348, 4'h0, '0, 1, 128'h33BBCCDD};
    vecs[4] = '{1'b0, TYPE_BYTE, 32'h34D, 4'h0, '0, 1, 128'h44444444};
    vecs[5] = '{1'b1, TYPE_HALF, 32'h344, 4'b1100, 128'h55667788, 0, '0};
    vecs[6] = '{1'b0, TYPE_HALF, 32'h346, 4'h0, '0, 1, 128'h55662222};
    vecs[7] = '{1'b0, TYPE_LINE, 32'h34C, 4'h0, '0, 4,
                128'h44444444_33BBCCDD_55662222_11111111};
    vecs[8] = '{1'b0, 3'b111, 32'h34C, 4'h0, '0, 1, 128'h44444444};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset ret_valid", 32'(ret_valid), 32'd0);
    check("reset ret_last", 32'(ret_last), 32'd0);
    check("reset ret_data", ret_data, 32'd0);
`ifdef CACHE_REFILL_MEM_INIT_EN
    begin
      int cnt;
      check("reset rd_rdy", 32'(rd_rdy), 32'd0);
      cnt = 0;
      while (!wr_rdy && cnt < 400) begin cnt++; @(negedge clk); end
      check("init sweep cycles", 32'(cnt), 32'd256);
    end
`else
    check("reset rd_rdy", 32'(rd_rdy), 32'd1);
    check("reset wr_rdy", 32'(wr_rdy), 32'd1);
    do_write(TYPE_LINE, 32'h120, 4'h0, pat120, "prefill120");
`endif
    do_read(TYPE_LINE, 32'h00000120, 4, pat120, "line120");
    do_read(TYPE_LINE, 32'h00100120, 4, pat120, "alias120");

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].typ, vecs[i].addr, vecs[i].strb, vecs[i].data, $sformatf("vec%0d", i));
      else
        do_read(vecs[i].typ, vecs[i].addr, vecs[i].nbeats, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Simultaneous requests: the write must win
    @(negedge clk);
    wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h500; wr_wstrb = '0;
    wr_data = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h500;
    #1;
    check("both rd_rdy", 32'(rd_rdy), 32'd0);
    check("both wr_rdy", 32'(wr_rdy), 32'd1);
    @(posedge clk);
    #1 wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("both wr_wait", 32'(wr_rdy), 32'd0);
    wait_ready("both");
    do_read(TYPE_LINE, 32'h500, 4, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, "both_read");

    // Reset during beat 2 of a burst
    @(negedge clk);
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h340;
    @(posedge clk);
    #1 rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rstburst beat2 valid", 32'(ret_valid), 32'd1);
    check("rstburst beat2 data", ret_data, 32'h55662222);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstburst valid", 32'(ret_valid), 32'd0);
    check("rstburst last", 32'(ret_last), 32'd0);
    check("rstburst data", ret_data, 32'd0);
    wait_ready("rstburst");

    // Reset during WR_WAIT: old line contents must survive
    @(negedge clk);
    wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h340; wr_wstrb = '0;
    wr_data = {4{32'hDEADBEEF}};
    @(posedge clk);
    #1 wr_req = 1'b0;
    @(negedge clk);
    check("rstwr in_wait", 32'(wr_rdy), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ready("rstwr");
`ifdef CACHE_REFILL_MEM_INIT_EN
    old340 = {32'h34C, 32'h348, 32'h344, 32'h340};
`else
    old340 = 128'h44444444_33BBCCDD_55662222_11111111;
`endif
    do_read(TYPE_LINE, 32'h340, 4, old340, "rstwr_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_refill_mem.md
# cache_refill_mem

Backing-memory responder sitting directly downstream of the cache's refill/write-back port. It accepts the cache's `rd_req` (refill) and `wr_req` (write-back / uncached store) handshakes and returns read data as 1- or 4-beat bursts on `ret_*` after a programmable latency. It holds line-granular storage and serves one request at a time. It is the memory model the cache test top instantiates in place of its ad-hoc responder logic.

## Interface
- `LINE_AW`, 8: line-index width; storage is 2^LINE_AW lines × 128 bits, indexed by `addr[LINE_AW+3:4]`, upper bits ignored (aliasing).
- `LATENCY`, 2: cycles from request acceptance to the first `ret_valid` or to the write commit; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rd_req` in 1: read request valid.
- `rd_type` in 3: 000 byte, 001 half, 010 word, 100 line.
- `rd_addr` in 32: read byte address.
- `rd_rdy` out 1: read request accepted when `rd_req && rd_rdy`.
- `ret_valid` out 1: return beat valid.
- `ret_last` out 1: final beat of the response.
- `ret_data` out 32: return beat data.
- `wr_req` in 1: write request valid.
- `wr_type` in 3: same encoding as `rd_type`.
- `wr_addr` in 32: write byte address.
- `wr_wstrb` in 4: byte strobes for non-line writes.
- `wr_data` in 128: line data; non-line writes use `[31:0]`.
- `wr_rdy` out 1: write request accepted when `wr_req && wr_rdy`.

## Operation
- FSM states: INIT (macro only), IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- `wr_rdy = (state==IDLE)`; `rd_rdy = (state==IDLE) && !wr_req`. When both requests are present, the write wins, so a write-back is always ordered before the refill that follows it.
- Read acceptance latches the line index, the word offset `addr[3:2]`, and the beat count (4 for type 100, otherwise 1). Any unsupported type is treated as a single-word read.
- Line read: four beats, word 0..3 in ascending order, one per consecutive cycle, no back-pressure. `ret_last` is asserted on beat 4.
- Single read: one beat returns the full 32-bit word at `addr[3:2]`, with `ret_last=1`. The cache extracts the byte or half itself.
- Array data is read at beat time. No write can interleave with a read.
- Line write: all 16 bytes are written and `wr_wstrb` is ignored.
- Non-line write: word `addr[3:2]` is updated with `wr_data[31:0]` under `wr_wstrb`.
- A write is committed on the clock edge that ends WR_WAIT.
- `ret_data` is 0 whenever `ret_valid` is 0.
- Reset mid-operation: the FSM returns to IDLE (or INIT). `ret_valid` is 0 from the next cycle. An uncommitted write is discarded. Storage is otherwise untouched.

## Timing
- Values after reset: `ret_valid=0`, `ret_last=0`, `ret_data=0`. `rd_rdy=wr_rdy=1` without the macro; both are 0 during INIT with the macro.
- Read accepted in cycle T: first beat in cycle T+LATENCY. RD_WAIT lasts LATENCY-1 cycles; with LATENCY=1 the FSM goes straight to RD_BURST.
- `rd_rdy`/`wr_rdy` are low from T+1 through the last beat. They are high in the cycle after `ret_last`.
- Write accepted in cycle T: WR_WAIT lasts LATENCY cycles, cycles T+1 through T+LATENCY. The write commits at the end of T+LATENCY, and `wr_rdy` returns high in T+LATENCY+1.
- The latency counter is 4 bits and the beat counter is 2 bits; both wrap-free by construction.

## Configuration
- `CACHE_REFILL_MEM_INIT_EN` defined:
  - After reset the FSM enters INIT and sweeps one line per cycle, 2^LINE_AW cycles in total.
  - Each word is written with its own byte address, `{line,word,2'b00}` zero-extended.
  - Both ready outputs stay low until the sweep finishes, then the FSM enters IDLE.
- Undefined: there is no INIT state. Contents are undefined until written, and the FSM enters IDLE directly.

## Structure
- Shared package `cache_pkg`:
  - rd/wr type codes (`TYPE_BYTE/HALF/WORD/LINE`).
  - FSM state encoding.
  - Line width 128 and word width 32.
- Sub-module `cache_mem_array`: 2^LINE_AW × 128 storage with one word-select read port and one write port carrying a 16-bit byte-enable. The top builds the byte-enable from the type and strobe.

## Test plan
All scenarios use LATENCY=2 and LINE_AW=8.
- INIT_EN, reset released: ready stays low for 256 cycles. Then a line read of `0x00000120` returns `0x120,0x124,0x128,0x12C` starting at T+2, with `ret_last` on beat 4.
- Line write to `0x00000340` with `wr_data=128'h44444444_33333333_22222222_11111111`, then a line read of `0x340`: beats `0x11111111,0x22222222,0x33333333,0x44444444`.
- Word write to `0x00000348` with `wstrb=0111`, `wr_data[31:0]=0xAABBCCDD`, then a word read of `0x348`: single beat `0x33BBCCDD` with `ret_last=1`; `wr_rdy` was low exactly 2 cycles.
- `rd_req` and `wr_req` both high in IDLE for line `0x500`: write accepted and `rd_rdy=0` that cycle. The later read returns the written data.
- Reset asserted during beat 2 of a burst: `ret_valid=0` from the next cycle. Reset during WR_WAIT: the old line contents remain.
- Read of `0x00100120` returns the same data as `0x00000120` (aliasing).
